// File: rtl/mem_port_arbiter.sv
// Shares one memory-controller port between the instruction-fetch and data ports.
// Data has priority; the instruction port wins after MAX_DATA_RUN consecutive data grants.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MEM_LAT      = 1,
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_write_val,
    input  logic [DATA_W-1:0] mem_read_val,
    output logic              busy,
    output logic              grant_data
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [2:0] LatLast = 3'(MEM_LAT - 1);
    localparam logic [3:0] RunMax  = 4'(MAX_DATA_RUN);

    state_e            state_q, state_d;
    logic [2:0]        lat_cnt_q, lat_cnt_d;
    logic [3:0]        run_cnt_q, run_cnt_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              data_wins;

    assign data_wins = d_req && !(i_req && (run_cnt_q == RunMax));

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        run_cnt_d = run_cnt_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    state_d   = StAccess;
                    lat_cnt_d = '0;
                    owner_d   = data_wins;
                    if (data_wins) begin
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                        // The run only counts while the instruction port is actually waiting
                        if (!i_req) begin
                            run_cnt_d = '0;
                        end else if (run_cnt_q != RunMax) begin
                            run_cnt_d = run_cnt_q + 4'd1;
                        end
                    end else begin
                        addr_d    = i_addr;
                        we_d      = 1'b0;
                        wdata_d   = '0;
                        run_cnt_d = '0;
                    end
                end
            end
            StAccess: begin
                if (lat_cnt_q == LatLast) begin
                    state_d = StResp;
                    if (!we_q) begin
                        if (owner_q) begin
                            d_rdata_d = mem_read_val;
                        end else begin
                            i_rdata_d = mem_read_val;
                        end
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            lat_cnt_q <= '0;
            run_cnt_q <= '0;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            run_cnt_q <= run_cnt_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Memory-side outputs decode only from registered state, so reset drops them at once
    always_comb begin
        busy          = (state_q != StIdle);
        mem_addr      = (state_q == StAccess) ? addr_q : '0;
        mem_read_en   = (state_q == StAccess) && !we_q;
        mem_write_en  = (state_q == StAccess) && we_q && (lat_cnt_q == 3'd0);
        mem_write_val = ((state_q == StAccess) && we_q) ? wdata_q : '0;
        i_ack         = (state_q == StResp) && !owner_q;
        d_ack         = (state_q == StResp) && owner_q;
        grant_data    = owner_q;
        i_rdata       = i_rdata_q;
        d_rdata       = d_rdata_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances with MEM_LAT 1, 3 and 4,
// each with its own requests and a small word-addressed memory model.
module tb_mem_port_arbiter;

    localparam int NDUT = 3;

    logic        clk;
    logic        reset;
    logic        mem_init;
    logic        i_req         [NDUT];
    logic        d_req         [NDUT];
    logic        d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_ack         [NDUT];
    logic        d_ack         [NDUT];
    logic        busy          [NDUT];
    logic        grant_data    [NDUT];
    logic        mem_read_en   [NDUT];
    logic        mem_write_en  [NDUT];
    logic [31:0] i_rdata       [NDUT];
    logic [31:0] d_rdata       [NDUT];
    logic [31:0] mem_addr      [NDUT];
    logic [31:0] mem_write_val [NDUT];
    logic [31:0] mem_read_val  [NDUT];
    logic [31:0] mem           [NDUT][256];

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mem_port_arbiter #(
            .ADDR_W      (32),
            .DATA_W      (32),
            .MEM_LAT     ((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
            .MAX_DATA_RUN(4)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .i_req        (i_req[g]),
            .i_addr       (i_addr),
            .i_ack        (i_ack[g]),
            .i_rdata      (i_rdata[g]),
            .d_req        (d_req[g]),
            .d_we         (d_we),
            .d_addr       (d_addr),
            .d_wdata      (d_wdata),
            .d_ack        (d_ack[g]),
            .d_rdata      (d_rdata[g]),
            .mem_addr     (mem_addr[g]),
            .mem_read_en  (mem_read_en[g]),
            .mem_write_en (mem_write_en[g]),
            .mem_write_val(mem_write_val[g]),
            .mem_read_val (mem_read_val[g]),
            .busy         (busy[g]),
            .grant_data   (grant_data[g])
        );
        assign mem_read_val[g] = mem[g][mem_addr[g][7:0]];
    end

    always @(posedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            for (int a = 0; a < 256; a++) begin
                if (mem_init) begin
                    mem[g][a] <= (a == 212) ? 32'h8C01_0004 : 32'h1000_0000 + 32'(a);
                end else if (mem_write_en[g] && (mem_addr[g][7:0] == 8'(a))) begin
                    mem[g][a] <= mem_write_val[g];
                end
            end
        end
    end

    function automatic int lat_of(input int s);
        return (s == 0) ? 1 : ((s == 1) ? 3 : 4);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // who: 1 = data ack, 0 = instruction ack, 2 = both at once, -1 = timeout
    task automatic next_ack(input int s, output int who, output int waited);
        who    = -1;
        waited = 0;
        while (who < 0 && waited < 30) begin
            @(negedge clk);
            waited++;
            if (i_ack[s] && d_ack[s]) who = 2;
            else if (d_ack[s])        who = 1;
            else if (i_ack[s])        who = 0;
        end
    endtask

    typedef struct {
        int          s;
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic run_vec(input vec_t v, input int idx);
        int   lat = lat_of(v.s);
        int   n = 0, ack_n = -1, rd_cnt = 0, wr_cnt = 0, hold_err = 0, other = 0;
        logic gd = 1'b0;
        @(negedge clk);
        if (v.is_d) begin
            d_we     = v.we;
            d_addr   = v.addr;
            d_wdata  = v.wdata;
            d_req[v.s] = 1'b1;
        end else begin
            i_addr   = v.addr;
            i_req[v.s] = 1'b1;
        end
        while (ack_n < 0 && n < 20) begin
            @(negedge clk);
            n++;
            if (mem_read_en[v.s])  rd_cnt++;
            if (mem_write_en[v.s]) wr_cnt++;
            if (n <= lat && (mem_addr[v.s] !== v.addr ||
                             (v.we && mem_write_val[v.s] !== v.wdata))) hold_err++;
            if (v.is_d ? i_ack[v.s] : d_ack[v.s]) other++;
            if (v.is_d ? d_ack[v.s] : i_ack[v.s]) begin
                ack_n = n;
                gd    = grant_data[v.s];
            end
        end
        d_req[v.s] = 1'b0;
        i_req[v.s] = 1'b0;
        check($sformatf("v%0d ack_cycle", idx), 64'(ack_n), 64'(lat + 1));
        check($sformatf("v%0d read_en_cycles", idx), 64'(rd_cnt), 64'(v.we ? 0 : lat));
        check($sformatf("v%0d write_en_cycles", idx), 64'(wr_cnt), 64'(v.we ? 1 : 0));
        check($sformatf("v%0d addr_val_hold", idx), 64'(hold_err), 64'd0);
        check($sformatf("v%0d other_ack", idx), 64'(other), 64'd0);
        check($sformatf("v%0d grant_data", idx), 64'(gd), 64'(v.is_d));
        check($sformatf("v%0d rdata", idx), 64'(v.is_d ? d_rdata[v.s] : i_rdata[v.s]),
              64'(v.exp_rdata));
        @(negedge clk);
        check($sformatf("v%0d after_ack", idx), {61'd0, i_ack[v.s], d_ack[v.s], busy[v.s]},
              64'd0);
        repeat (2) @(negedge clk);
    endtask

    vec_t vecs[10];
    int   exp_order[10];
    int   who, w, cnt_d, cnt_i, cnt_b;

    initial begin
        vecs[0] = '{s: 0, is_d: 0, we: 0, addr: 212, wdata: 0,            exp_rdata: 32'h8C01_0004};
        vecs[1] = '{s: 1, is_d: 1, we: 1, addr: 5,   wdata: 32'hDEAD_BEEF, exp_rdata: 32'h0};
        vecs[2] = '{s: 1, is_d: 1, we: 0, addr: 5,   wdata: 0,            exp_rdata: 32'hDEAD_BEEF};
        vecs[3] = '{s: 1, is_d: 0, we: 0, addr: 5,   wdata: 0,            exp_rdata: 32'hDEAD_BEEF};
        vecs[4] = '{s: 1, is_d: 1, we: 1, addr: 6,   wdata: 32'h1234_5678, exp_rdata: 32'hDEAD_BEEF};
        vecs[5] = '{s: 2, is_d: 1, we: 0, addr: 7,   wdata: 0,            exp_rdata: 32'h1000_0007};
        vecs[6] = '{s: 0, is_d: 1, we: 0, addr: 212, wdata: 0,            exp_rdata: 32'h8C01_0004};
        vecs[7] = '{s: 2, is_d: 0, we: 0, addr: 0,   wdata: 0,            exp_rdata: 32'h1000_0000};
        vecs[8] = '{s: 0, is_d: 1, we: 1, addr: 212, wdata: 32'h0,        exp_rdata: 32'h8C01_0004};
        vecs[9] = '{s: 0, is_d: 0, we: 0, addr: 212, wdata: 0,            exp_rdata: 32'h0};
        exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        reset    = 1'b1;
        mem_init = 1'b1;
        d_we     = 1'b0;
        i_addr   = '0;
        d_addr   = '0;
        d_wdata  = '0;
        for (int g = 0; g < NDUT; g++) begin
            i_req[g] = 1'b0;
            d_req[g] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("reset ctrl dut%0d", g),
                  {58'd0, i_ack[g], d_ack[g], busy[g], grant_data[g], mem_read_en[g],
                   mem_write_en[g]}, 64'd0);
            check($sformatf("reset mem bus dut%0d", g), {mem_addr[g], mem_write_val[g]}, 64'd0);
            check($sformatf("reset rdata dut%0d", g), {i_rdata[g], d_rdata[g]}, 64'd0);
        end
        mem_init = 1'b0;
        reset    = 1'b0;

        for (int k = 0; k < 10; k++) run_vec(vecs[k], k);

        // Both ports held continuously: data runs of four, then one instruction grant
        do_reset();
        @(negedge clk);
        i_addr   = 20;
        d_addr   = 30;
        d_we     = 1'b0;
        i_req[1] = 1'b1;
        d_req[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            next_ack(1, who, w);
            check($sformatf("arb order %0d", k), 64'(who), 64'(exp_order[k]));
            check($sformatf("arb spacing %0d", k), 64'(w), 64'((k == 0) ? 4 : 5));
        end
        i_req[1] = 1'b0;
        d_req[1] = 1'b0;
        check("arb i_rdata", 64'(i_rdata[1]), 64'h1000_0014);
        check("arb d_rdata", 64'(d_rdata[1]), 64'h1000_001E);
        repeat (6) @(negedge clk);

        // Simultaneous requests from reset: data first, instruction MEM_LAT+2 later
        do_reset();
        @(negedge clk);
        i_req[2] = 1'b1;
        d_req[2] = 1'b1;
        next_ack(2, who, w);
        check("simul first", 64'(who), 64'd1);
        check("simul first cycle", 64'(w), 64'd5);
        d_req[2] = 1'b0;
        next_ack(2, who, w);
        check("simul second", 64'(who), 64'd0);
        check("simul gap", 64'(w), 64'd6);
        i_req[2] = 1'b0;
        repeat (6) @(negedge clk);

        // Reset in the middle of a data read; run count must restart from zero
        do_reset();
        @(negedge clk);
        i_req[2] = 1'b1;
        d_req[2] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            next_ack(2, who, w);
            check($sformatf("pre-reset grant %0d", k), 64'(who), 64'd1);
        end
        repeat (3) @(negedge clk);
        check("pre-reset read_en", 64'(mem_read_en[2]), 64'd1);
        #1 reset = 1'b1;
        #1;
        check("abort enables", {62'd0, mem_read_en[2], busy[2]}, 64'd0);
        cnt_d = 0;
        repeat (2) begin
            @(negedge clk);
            if (d_ack[2] || i_ack[2]) cnt_d++;
        end
        check("abort no ack", 64'(cnt_d), 64'd0);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            next_ack(2, who, w);
            check($sformatf("post-reset order %0d", k), 64'(who), 64'((k == 4) ? 0 : 1));
            check($sformatf("post-reset spacing %0d", k), 64'(w), 64'((k == 0) ? 5 : 6));
            if (k == 0) check("post-reset d_rdata", 64'(d_rdata[2]), 64'h1000_001E);
        end
        i_req[2] = 1'b0;
        d_req[2] = 1'b0;
        repeat (8) @(negedge clk);

        // Request withdrawn during ACCESS still completes exactly once
        do_reset();
        @(negedge clk);
        d_addr   = 9;
        d_we     = 1'b0;
        d_req[1] = 1'b1;
        @(negedge clk);
        d_req[1] = 1'b0;
        cnt_d = 0;
        cnt_i = 0;
        cnt_b = 0;
        repeat (12) begin
            @(negedge clk);
            if (d_ack[1]) cnt_d++;
            if (i_ack[1]) cnt_i++;
            if (busy[1])  cnt_b++;
        end
        check("drop d_ack count", 64'(cnt_d), 64'd1);
        check("drop i_ack count", 64'(cnt_i), 64'd0);
        check("drop busy cycles", 64'(cnt_b), 64'd3);
        check("drop d_rdata", 64'(d_rdata[1]), 64'h1000_0009);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
